prng_err_vec_gen: RTL

Random error-position generator for Niederreiter encryption. Sits directly downstream of the x^25+x^3+1 LFSR PRNG and drives its `prng_typ_sel` control. It carves fresh `IDX_W`-bit candidates out of `prng_r_dat`, rejects out-of-range and duplicate candidates, and collects `T_ERR` distinct positions in `[0, N_LEN)`. It then streams them with a valid/ready handshake to the syndrome-computation datapath.

---
 rtl/prng_err_vec_gen.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/prng_err_vec_gen.sv
// Random error-position generator: pulls IDX_W-bit candidates from the LFSR PRNG,
// keeps T_ERR distinct positions below N_LEN and streams them out. Define
// PRNG_ERR_SORT_EN to store and emit the positions in ascending order.
module prng_err_vec_gen #(
  parameter int PRNG_DAT_W = 25,
  parameter int PRNG_TYP_W = 2,
  parameter int IDX_W      = 11,
  parameter int N_LEN      = 1800,
  parameter int T_ERR      = 27
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic [PRNG_TYP_W-1:0] prng_typ_sel,
  input  logic [PRNG_DAT_W-1:0] prng_r_dat,
  output logic [IDX_W-1:0]      pos_dat,
  output logic                  pos_vld,
  input  logic                  pos_rdy,
  output logic                  done
);

  localparam int SH_W  = $clog2(IDX_W + 1);
  localparam int CNT_W = $clog2(T_ERR + 1);
  localparam logic [IDX_W:0]        N_LIM     = (IDX_W + 1)'(N_LEN);
  localparam logic [PRNG_TYP_W-1:0] TYP_HALT  = '0;
  localparam logic [PRNG_TYP_W-1:0] TYP_SHIFT = PRNG_TYP_W'(1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t           state;
  logic             typ_d;
  logic [SH_W-1:0]  sh_cnt;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] rd_ptr;
  logic [IDX_W-1:0] err_buf [T_ERR];
  logic [IDX_W-1:0] buf_nxt [T_ERR];

  logic [IDX_W-1:0] cand;
  logic             cand_evt;
  logic             in_range;
  logic             dup_hit;
  logic             accept;
  logic             last_acc;
  logic [CNT_W-1:0] rd_nxt;
  logic [IDX_W-1:0] rd_nxt_dat;
  logic             hs;
  logic             last_hs;

  // Only the low IDX_W bits of each PRNG word feed a candidate.
  if (PRNG_DAT_W > IDX_W) begin : g_unused
    logic unused_prng_bits;
    assign unused_prng_bits = ^prng_r_dat[PRNG_DAT_W-1:IDX_W];
  end

  assign cand     = prng_r_dat[IDX_W-1:0];
  assign cand_evt = (state == FILL) && (sh_cnt == SH_W'(IDX_W));
  assign in_range = {1'b0, cand} < N_LIM;
  assign accept   = cand_evt && in_range && !dup_hit;
  assign last_acc = (acc_cnt == CNT_W'(T_ERR - 1));
  assign hs       = pos_vld && pos_rdy;
  assign last_hs  = (rd_ptr == CNT_W'(T_ERR - 1));
  assign rd_nxt   = rd_ptr + 1'b1;

  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < T_ERR; i++) begin
      if ((CNT_W'(i) < acc_cnt) && (err_buf[i] == cand)) dup_hit = 1'b1;
    end
  end

  always_comb begin
    rd_nxt_dat = '0;
    for (int i = 0; i < T_ERR; i++) begin
      if (CNT_W'(i) == rd_nxt) rd_nxt_dat = err_buf[i];
    end
  end

`ifdef PRNG_ERR_SORT_EN
  // Stored entries stay sorted, so the "greater than cand" flags form one
  // contiguous run that moves up by a slot to make room for cand.
  logic [T_ERR-1:0] gt;

  always_comb begin
    for (int i = 0; i < T_ERR; i++) begin
      gt[i] = (CNT_W'(i) < acc_cnt) && (err_buf[i] > cand);
    end
    buf_nxt[0] = (gt[0] || (acc_cnt == '0)) ? cand : err_buf[0];
    for (int i = 1; i < T_ERR; i++) begin
      if (gt[i-1])                             buf_nxt[i] = err_buf[i-1];
      else if (gt[i] || (CNT_W'(i) == acc_cnt)) buf_nxt[i] = cand;
      else                                     buf_nxt[i] = err_buf[i];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < T_ERR; i++) begin
      buf_nxt[i] = (CNT_W'(i) == acc_cnt) ? cand : err_buf[i];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (accept) err_buf <= buf_nxt;
  end

  // The PRNG registers its command, so typ_d tells us whether the LFSR
  // actually shifts on the coming edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      prng_typ_sel <= TYP_HALT;
      typ_d        <= 1'b0;
      sh_cnt       <= '0;
      acc_cnt      <= '0;
      rd_ptr       <= '0;
      pos_dat      <= '0;
      pos_vld      <= 1'b0;
      done         <= 1'b0;
    end else begin
      typ_d <= (prng_typ_sel == TYP_SHIFT);
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done) begin
            state        <= FILL;
            busy         <= 1'b1;
            prng_typ_sel <= TYP_SHIFT;
            acc_cnt      <= '0;
            sh_cnt       <= '0;
            rd_ptr       <= '0;
          end
        end
        FILL: begin
          if (cand_evt)   sh_cnt <= typ_d ? SH_W'(1) : '0;
          else if (typ_d) sh_cnt <= sh_cnt + 1'b1;
          if (accept) begin
            acc_cnt <= acc_cnt + 1'b1;
            if (last_acc) begin
              state        <= DRAIN;
              prng_typ_sel <= TYP_HALT;
              pos_dat      <= buf_nxt[0];
              pos_vld      <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (hs) begin
            if (last_hs) begin
              state   <= IDLE;
              pos_vld <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              rd_ptr  <= rd_nxt;
              pos_dat <= rd_nxt_dat;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
